// File: rtl/playback_sequencer.sv
// Segment scheduler for the channel pattern RAM: plays a table of address segments in order,
// each repeated rep+1 times, driving one RAM read address per cycle, optionally looping the list.
module playback_sequencer #(
    parameter int unsigned N_ADDR_BITS = 20,
    parameter int unsigned MEM_DEPTH   = 1048576,
    parameter int unsigned NSEG        = 8,
    parameter int unsigned SEG_BITS    = 3,
    parameter int unsigned REP_BITS    = 16
) (
    input  logic                   playback_clk,
    input  logic                   s_axi_reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   loop_all,
    input  logic [SEG_BITS:0]      n_segments,
    input  logic                   tbl_wen,
    input  logic [SEG_BITS-1:0]    tbl_idx,
    input  logic [N_ADDR_BITS-1:0] tbl_start,
    input  logic [N_ADDR_BITS-1:0] tbl_stop,
    input  logic [REP_BITS-1:0]    tbl_rep,
    output logic [N_ADDR_BITS-1:0] ram_addr,
    output logic                   playing,
    output logic [SEG_BITS-1:0]    seg_idx,
    output logic                   seg_start,
    output logic                   busy,
    output logic                   done,
    output logic                   tbl_err
);

    localparam logic [N_ADDR_BITS-1:0] AddrLast = N_ADDR_BITS'(MEM_DEPTH - 1);
    localparam logic [SEG_BITS:0]      NsegMax  = (SEG_BITS + 1)'(NSEG);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                 state_q;
    logic                   start_q;
    logic [N_ADDR_BITS-1:0] ram_addr_q;
    logic [SEG_BITS-1:0]    seg_idx_q;
    logic [REP_BITS-1:0]    rep_cnt_q;
    logic                   playing_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   seg_start_q;
    logic                   tbl_err_q;

    logic [N_ADDR_BITS-1:0] start_tbl_q [NSEG];
    logic [N_ADDR_BITS-1:0] stop_tbl_q  [NSEG];
    logic [REP_BITS-1:0]    rep_tbl_q   [NSEG];

    logic                   start_edge;
    logic                   tbl_wr;
    logic                   at_stop;
    logic                   last_seg;
    logic [SEG_BITS:0]      nseg_eff;
    logic [SEG_BITS-1:0]    seg_next;
    logic [N_ADDR_BITS-1:0] addr_inc;
    logic [N_ADDR_BITS-1:0] first_start;
    logic [REP_BITS-1:0]    first_rep;

    always_comb begin
        start_edge = start & ~start_q;
        tbl_wr     = tbl_wen && (state_q != StRun);
        nseg_eff   = (n_segments > NsegMax) ? NsegMax : n_segments;
        seg_next   = seg_idx_q + SEG_BITS'(1);
        last_seg   = ({1'b0, seg_idx_q} + (SEG_BITS + 1)'(1)) >= nseg_eff;
        at_stop    = (ram_addr_q == stop_tbl_q[seg_idx_q]);
        addr_inc   = (ram_addr_q == AddrLast) ? '0 : ram_addr_q + N_ADDR_BITS'(1);
        // A write to entry 0 on the launch edge must be seen by the run it launches.
        first_start = start_tbl_q[0];
        first_rep   = rep_tbl_q[0];
        if (tbl_wr && (tbl_idx == '0)) begin
            first_start = tbl_start;
            first_rep   = tbl_rep;
        end
    end

    always_ff @(posedge playback_clk or negedge s_axi_reset) begin
        if (!s_axi_reset) begin
            state_q     <= StIdle;
            start_q     <= 1'b0;
            ram_addr_q  <= '0;
            seg_idx_q   <= '0;
            rep_cnt_q   <= '0;
            playing_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            seg_start_q <= 1'b0;
            tbl_err_q   <= 1'b0;
            start_tbl_q <= '{default: '0};
            stop_tbl_q  <= '{default: AddrLast};
            rep_tbl_q   <= '{default: '0};
        end else begin
            start_q     <= start;
            tbl_err_q   <= tbl_wen && (state_q == StRun);
            seg_start_q <= 1'b0;
            if (tbl_wr) begin
                start_tbl_q[tbl_idx] <= tbl_start;
                stop_tbl_q[tbl_idx]  <= tbl_stop;
                rep_tbl_q[tbl_idx]   <= tbl_rep;
            end
            if (abort) begin
                state_q    <= StIdle;
                ram_addr_q <= '0;
                seg_idx_q  <= '0;
                rep_cnt_q  <= '0;
                playing_q  <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b0;
            end else if (start_edge && (state_q != StRun)) begin
                if (nseg_eff != '0) begin
                    state_q     <= StRun;
                    ram_addr_q  <= first_start;
                    seg_idx_q   <= '0;
                    rep_cnt_q   <= first_rep;
                    playing_q   <= 1'b1;
                    busy_q      <= 1'b1;
                    seg_start_q <= 1'b1;
                    done_q      <= 1'b0;
                end else begin
                    state_q   <= StDone;
                    playing_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                end
            end else if (state_q == StRun) begin
                if (!at_stop) begin
                    ram_addr_q <= addr_inc;
                end else if (rep_cnt_q != '0) begin
                    ram_addr_q <= start_tbl_q[seg_idx_q];
                    rep_cnt_q  <= rep_cnt_q - REP_BITS'(1);
                end else if (!last_seg) begin
                    seg_idx_q   <= seg_next;
                    ram_addr_q  <= start_tbl_q[seg_next];
                    rep_cnt_q   <= rep_tbl_q[seg_next];
                    seg_start_q <= 1'b1;
                end else if (loop_all) begin
                    seg_idx_q   <= '0;
                    ram_addr_q  <= start_tbl_q[0];
                    rep_cnt_q   <= rep_tbl_q[0];
                    seg_start_q <= 1'b1;
                end else begin
                    // ram_addr keeps the final stop word.
                    state_q   <= StDone;
                    playing_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                end
            end
        end
    end

    assign ram_addr  = ram_addr_q;
    assign playing   = playing_q;
    assign seg_idx   = seg_idx_q;
    assign seg_start = seg_start_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tbl_err   = tbl_err_q;

endmodule

// File: tb/tb_playback_sequencer.sv
// Self-checking bench for playback_sequencer: directed and random segment tables compared
// against a list-expanding reference model of the expected address stream.
module tb_playback_sequencer;

    localparam int AW   = 20;
    localparam int MEM  = 1048576;
    localparam int NSEG = 8;
    localparam int SB   = 3;
    localparam int RB   = 16;

    logic          playback_clk;
    logic          s_axi_reset;
    logic          start;
    logic          abort;
    logic          loop_all;
    logic [SB:0]   n_segments;
    logic          tbl_wen;
    logic [SB-1:0] tbl_idx;
    logic [AW-1:0] tbl_start;
    logic [AW-1:0] tbl_stop;
    logic [RB-1:0] tbl_rep;
    logic [AW-1:0] ram_addr;
    logic          playing;
    logic [SB-1:0] seg_idx;
    logic          seg_start;
    logic          busy;
    logic          done;
    logic          tbl_err;

    int checks = 0;
    int errors = 0;

    int m_start [NSEG];
    int m_stop  [NSEG];
    int m_rep   [NSEG];

    int exp_addr [$];
    int exp_seg  [$];
    bit exp_ss   [$];

    playback_sequencer #(
        .N_ADDR_BITS(AW),
        .MEM_DEPTH  (MEM),
        .NSEG       (NSEG),
        .SEG_BITS   (SB),
        .REP_BITS   (RB)
    ) dut (
        .playback_clk(playback_clk),
        .s_axi_reset (s_axi_reset),
        .start       (start),
        .abort       (abort),
        .loop_all    (loop_all),
        .n_segments  (n_segments),
        .tbl_wen     (tbl_wen),
        .tbl_idx     (tbl_idx),
        .tbl_start   (tbl_start),
        .tbl_stop    (tbl_stop),
        .tbl_rep     (tbl_rep),
        .ram_addr    (ram_addr),
        .playing     (playing),
        .seg_idx     (seg_idx),
        .seg_start   (seg_start),
        .busy        (busy),
        .done        (done),
        .tbl_err     (tbl_err)
    );

    initial begin
        playback_clk = 1'b0;
        forever #5 playback_clk = ~playback_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic init_model();
        for (int i = 0; i < NSEG; i++) begin
            m_start[i] = 0;
            m_stop[i]  = MEM - 1;
            m_rep[i]   = 0;
        end
    endtask

    // Expand the segment list into the word stream it should produce.
    task automatic build_seq(input int n, input bit lp, input int max_len);
        int nn, s, a, k;
        bit full, list_end, seg_end;
        exp_addr.delete();
        exp_seg.delete();
        exp_ss.delete();
        nn = (n > NSEG) ? NSEG : n;
        s = 0;
        full = 0;
        list_end = (nn == 0);
        while (!full && !list_end) begin
            for (int p = 0; p <= m_rep[s] && !full; p++) begin
                a = m_start[s];
                k = 0;
                seg_end = 0;
                while (!seg_end && !full) begin
                    exp_addr.push_back(a);
                    exp_seg.push_back(s);
                    exp_ss.push_back((p == 0) && (k == 0));
                    if (exp_addr.size() >= max_len) full = 1;
                    else if (a == m_stop[s]) seg_end = 1;
                    else begin
                        a = (a + 1) % MEM;
                        k++;
                    end
                end
            end
            s++;
            if (s >= nn) begin
                if (lp) s = 0;
                else list_end = 1;
            end
        end
    endtask

    task automatic write_entry(input int idx, input int s, input int e, input int r);
        tbl_wen   = 1'b1;
        tbl_idx   = SB'(idx);
        tbl_start = AW'(s);
        tbl_stop  = AW'(e);
        tbl_rep   = RB'(r);
        m_start[idx] = s;
        m_stop[idx]  = e;
        m_rep[idx]   = r;
        @(negedge playback_clk);
        tbl_wen = 1'b0;
    endtask

    // Returns at the negedge where the first word should be visible.
    task automatic start_run();
        start = 1'b1;
        @(negedge playback_clk);
        start = 1'b0;
    endtask

    task automatic check_seq(input string name, input bit expect_done);
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i > 0) @(negedge playback_clk);
            checks++;
            if (ram_addr !== AW'(exp_addr[i]) || seg_idx !== SB'(exp_seg[i])) begin
                errors++;
                $display("FAIL %s word %0d: got addr %0d seg %0d, want addr %0d seg %0d",
                         name, i, ram_addr, seg_idx, exp_addr[i], exp_seg[i]);
            end
            checks++;
            if ({playing, busy, done, seg_start} !== {3'b110, exp_ss[i]}) begin
                errors++;
                $display("FAIL %s flags word %0d: got play/busy/done/ss %b, want %b",
                         name, i, {playing, busy, done, seg_start}, {3'b110, exp_ss[i]});
            end
        end
        if (expect_done) begin
            @(negedge playback_clk);
            checks++;
            if ({playing, busy, done} !== 3'b001 ||
                ram_addr !== AW'(exp_addr[exp_addr.size()-1])) begin
                errors++;
                $display("FAIL %s done: got play/busy/done %b addr %0d, want 001 addr %0d",
                         name, {playing, busy, done}, ram_addr, exp_addr[exp_addr.size()-1]);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({ram_addr, playing, seg_idx, seg_start, busy, done, tbl_err} !== '0) begin
            errors++;
            $display("FAIL %s: got addr %0d play %b seg %0d ss %b busy %b done %b err %b, want all 0",
                     name, ram_addr, playing, seg_idx, seg_start, busy, done, tbl_err);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge playback_clk);
        check_all_zero("reset_held");
        s_axi_reset = 1'b1;
        @(negedge playback_clk);
        check_all_zero("reset_released");
    endtask

    task automatic test_basic();
        write_entry(0, 10, 13, 0);
        n_segments = 4'd1;
        build_seq(1, 0, 100);
        start_run();
        check_seq("basic", 1);
    endtask

    task automatic test_chain();
        write_entry(0, 0, 1, 1);
        write_entry(1, 100, 100, 0);
        n_segments = 4'd2;
        build_seq(2, 0, 100);
        start_run();
        check_seq("chain", 1);
    endtask

    task automatic test_wrap();
        write_entry(0, MEM - 2, 1, 0);
        n_segments = 4'd1;
        build_seq(1, 0, 100);
        start_run();
        check_seq("wrap", 1);
    endtask

    task automatic test_loop_abort();
        write_entry(0, 5, 6, 0);
        n_segments = 4'd1;
        loop_all = 1'b1;
        build_seq(1, 1, 7);
        start_run();
        fork
            check_seq("loop", 0);
            begin
                repeat (6) @(negedge playback_clk);
                abort = 1'b1;
            end
        join
        @(negedge playback_clk);
        abort = 1'b0;
        loop_all = 1'b0;
        check_all_zero("abort_idle");
        @(negedge playback_clk);
        check_all_zero("abort_idle_hold");
    endtask

    task automatic test_reject();
        write_entry(0, 200, 219, 0);
        n_segments = 4'd1;
        build_seq(1, 0, 100);
        start_run();
        fork
            check_seq("reject_run", 1);
            begin
                repeat (3) @(negedge playback_clk);
                tbl_wen   = 1'b1;
                tbl_idx   = '0;
                tbl_start = AW'(500);
                tbl_stop  = AW'(501);
                tbl_rep   = RB'(3);
                @(negedge playback_clk);
                tbl_wen = 1'b0;
                checks++;
                if (tbl_err !== 1'b1) begin
                    errors++;
                    $display("FAIL tbl_err_pulse: got %b, want 1", tbl_err);
                end
                @(negedge playback_clk);
                checks++;
                if (tbl_err !== 1'b0) begin
                    errors++;
                    $display("FAIL tbl_err_one_cycle: got %b, want 0", tbl_err);
                end
            end
        join
        start_run();
        check_seq("reject_readback", 1);
    endtask

    task automatic test_zero_segments();
        abort = 1'b1;
        @(negedge playback_clk);
        abort = 1'b0;
        n_segments = '0;
        start_run();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({playing, busy, done} !== 3'b001) begin
                errors++;
                $display("FAIL zero_seg cycle %0d: got play/busy/done %b, want 001",
                         i, {playing, busy, done});
            end
            @(negedge playback_clk);
        end
    endtask

    task automatic test_write_on_start();
        n_segments = 4'd1;
        tbl_wen   = 1'b1;
        tbl_idx   = '0;
        tbl_start = AW'(300);
        tbl_stop  = AW'(302);
        tbl_rep   = RB'(1);
        m_start[0] = 300;
        m_stop[0]  = 302;
        m_rep[0]   = 1;
        start = 1'b1;
        @(negedge playback_clk);
        tbl_wen = 1'b0;
        start = 1'b0;
        build_seq(1, 0, 100);
        check_seq("write_on_start", 1);
    endtask

    task automatic test_random();
        int n, s, len;
        for (int it = 0; it < 8; it++) begin
            for (int e = 0; e < NSEG; e++) begin
                s   = $urandom_range(0, MEM - 1);
                len = $urandom_range(0, 5);
                write_entry(e, s, (s + len) % MEM, $urandom_range(0, 2));
            end
            n = $urandom_range(1, 15);
            n_segments = (SB + 1)'(n);
            build_seq(n, 0, 1000);
            start_run();
            check_seq("random", 1);
        end
    endtask

    task automatic test_async_reset();
        write_entry(0, 1000, 1100, 0);
        n_segments = 4'd1;
        start_run();
        repeat (5) @(negedge playback_clk);
        #2;
        s_axi_reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge playback_clk);
        s_axi_reset = 1'b1;
        init_model();
        @(negedge playback_clk);
        build_seq(1, 0, 20);
        start_run();
        check_seq("reset_default_table", 0);
        abort = 1'b1;
        @(negedge playback_clk);
        abort = 1'b0;
    endtask

    initial begin
        s_axi_reset = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        loop_all    = 1'b0;
        n_segments  = '0;
        tbl_wen     = 1'b0;
        tbl_idx     = '0;
        tbl_start   = '0;
        tbl_stop    = '0;
        tbl_rep     = '0;
        init_model();
        test_reset();
        test_basic();
        test_chain();
        test_wrap();
        test_loop_abort();
        test_reject();
        test_zero_segments();
        test_write_on_start();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
